fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues single-outstanding requests to instruction memory
//  and presents {pc, pc+4, instr} with a valid flag to the IF/ID pipeline register (stage load = !stall).
//  Absorbs back-pressure (stall) and control-flow redirects (taken branch/jump from EX) without loss or duplication.
// PARAMETERS
//  XLEN      32            PC/address width
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     asynchronous, active-low reset
//  stall         in   1     1 = downstream not loading; hold if_* outputs
//  redirect      in   1     1 = flush fetch, restart at redirect_pc
//  redirect_pc   in   XLEN  new fetch address
//  imem_req      out  1     request valid
//  imem_addr     out  XLEN  request address (= pc)
//  imem_gnt      in   1     request accepted this cycle
//  imem_rvalid   in   1     read data valid (one-cycle pulse, >=1 cycle after gnt)
//  imem_rdata    in   32    instruction word
//  if_valid      out  1     if_* outputs hold a valid instruction
//  if_pc         out  XLEN  address of if_instr
//  if_pc_plus4   out  XLEN  if_pc + 4
//  if_instr      out  32    instruction
//  if_misalign   out  1     only with FETCH_MISALIGN_TRAP_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0): pc=RESET_PC, state=S_REQ, if_valid=0, skid empty, if_pc/if_pc_plus4/if_instr=0, imem_req=0.
//  FSM, one request in flight max:
//   S_REQ : imem_req = !skid_full & !redirect. gnt -> S_WAIT. redirect -> pc<=redirect_pc, stay.
//   S_WAIT: rvalid & !redirect -> capture {pc,rdata}, pc<=pc+4, S_REQ. rvalid & redirect -> discard,
//           pc<=redirect_pc, S_REQ. redirect w/o rvalid -> pc<=redirect_pc, S_DROP.
//   S_DROP: imem_req=0; rvalid -> discard, S_REQ. redirect -> pc<=redirect_pc (later redirect wins).
//  imem_addr = pc, stable while imem_req=1 and no gnt (redirect deasserts req in the same cycle).
//  Output slot + 1-entry skid buffer:
//   capture goes to slot if (!if_valid | !stall), else to skid.
//   !stall & skid full -> slot <= skid, skid empties; capture impossible that cycle (req blocked).
//   !stall & no capture & skid empty -> if_valid<=0.
//   redirect: if_valid<=0 and skid emptied same edge (flush beats stall and capture).
//  Latency: gnt in cycle N, rvalid in N+k (k>=1) -> if_valid=1 from edge ending N+k; next req in N+k+1.
//  Throughput: 1 instr / 2 cycles with zero-wait memory.
//  Arithmetic: pc+4 modulo 2^XLEN (0xFFFF_FFFC + 4 -> 0x0000_0000, no flag).
//  Reset mid-request: state, pc, slot, skid cleared immediately; any later rvalid for the old request
//   arriving in S_REQ is ignored (no capture outside S_WAIT).
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 -> no imem request; after the redirect edge,
//   slot loads if_valid=1, if_misalign=1, if_pc=redirect_pc, if_instr=32'h0000_0013 (NOP); FSM parks in
//   S_REQ with req=0 until next redirect or reset. if_misalign resets to 0, cleared by redirect.
//  Undefined: redirect_pc[1:0] forced to 2'b00; if_misalign port absent.
// TESTING
//  1 Reset release, gnt=1 always, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000 -> if_pc 0,4,8,...
//    each valid for 1 of 2 cycles, if_pc_plus4=if_pc+4, instr matches.
//  2 stall=1 for 5 cycles while instr@0x8 in slot and 0xC in flight -> slot holds 0x8, 0xC to skid,
//    imem_req=0; stall drop -> 0x8 consumed, 0xC next cycle, 0x10 fetched after; none lost/duplicated.
//  3 redirect to 0x100 in S_WAIT (rvalid 3 cycles later) -> old data discarded, if_valid=0,
//    next imem_addr=0x100, first if_pc=0x100.
//  4 redirect and rvalid same cycle, stall=1, slot full -> slot and skid flushed, next req 0x200.
//  5 rst pulse low mid-S_WAIT, stale rvalid after release -> ignored; first if_pc=RESET_PC.
//  6 With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 -> if_misalign=1, if_pc=0x102, no imem_req;
//    without macro -> imem_addr=0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC owner, single-outstanding imem requests, IF/ID slot + 1-entry skid.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise if_misalign instead of fetching.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            if_misalign,
`endif
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [31:0]     if_instr
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    localparam logic [31:0]     NOP  = 32'h0000_0013;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_pc4;
    logic [31:0]     r_if_instr;
    logic            r_skid_v;
    logic [XLEN-1:0] r_skid_pc;
    logic [31:0]     r_skid_instr;

    logic [XLEN-1:0] w_rpc;
    logic            w_bad;
    logic            w_park;
    logic            w_req;
    logic            w_capture;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_park;
    logic r_misalign;

    assign w_rpc  = redirect_pc;
    assign w_bad  = |redirect_pc[1:0];
    assign w_park = r_park;

    // Park the FSM after a misaligned redirect; any later redirect decides again
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_park     <= 1'b0;
            r_misalign <= 1'b0;
        end else if (redirect) begin
            r_park     <= w_bad;
            r_misalign <= w_bad;
        end
    end

    assign if_misalign = r_misalign;
`else
    assign w_rpc  = redirect_pc & ~XLEN'(3);
    assign w_bad  = 1'b0;
    assign w_park = 1'b0;
`endif

    // Request only when idle, skid free, not flushing, and out of reset
    assign w_req = rst & (r_state == S_REQ) & ~r_skid_v
                 & ~redirect & ~w_park;
    assign w_capture = (r_state == S_WAIT) & imem_rvalid & ~redirect;

    assign imem_req  = w_req;
    assign imem_addr = r_pc;

    // Fetch FSM: one request in flight, stale responses dropped after redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (redirect)
                        r_pc <= w_rpc;
                    else if (w_req && imem_gnt)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                        r_pc    <= redirect ? w_rpc : r_pc + FOUR;
                    end else if (redirect) begin
                        r_state <= S_DROP;
                        r_pc    <= w_rpc;
                    end
                end
                S_DROP: begin
                    if (redirect)
                        r_pc <= w_rpc;
                    if (imem_rvalid)
                        r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    // Output slot and skid: flush first, then drain skid, then capture, else retire
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_valid   <= 1'b0;
            r_if_pc      <= '0;
            r_if_pc4     <= '0;
            r_if_instr   <= '0;
            r_skid_v     <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
        end else if (redirect) begin
            r_if_valid <= w_bad;
            r_skid_v   <= 1'b0;
            if (w_bad) begin
                r_if_pc    <= redirect_pc;
                r_if_pc4   <= redirect_pc + FOUR;
                r_if_instr <= NOP;
            end
        end else if (!stall && r_skid_v) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_skid_pc;
            r_if_pc4   <= r_skid_pc + FOUR;
            r_if_instr <= r_skid_instr;
            r_skid_v   <= 1'b0;
        end else if (w_capture) begin
            if (!r_if_valid || !stall) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_pc;
                r_if_pc4   <= r_pc + FOUR;
                r_if_instr <= imem_rdata;
            end else begin
                r_skid_v     <= 1'b1;
                r_skid_pc    <= r_pc;
                r_skid_instr <= imem_rdata;
            end
        end else if (!stall) begin
            r_if_valid <= 1'b0;
        end
    end

    assign if_valid    = r_if_valid;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc4;
    assign if_instr    = r_if_instr;

endmodule
